// File: rtl/register_bank_arbiter.sv
// Two-requester write arbiter in front of a small register bank.
// Round-robin grant in IDLE, one-cycle COMMIT writes the held request.

module register_bank_reg #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  q <= '0;
      else if (en) q <= d;
   end
endmodule

module register_bank_arbiter #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              wr_done,
   output logic              wr_src
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {IDLE = 1'b0, COMMIT = 1'b1} state_t;

   typedef struct packed {
      logic              src;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } hold_t;

   state_t state, nxt;
   logic   prio;
   hold_t  hold;
   logic   xfer;

   logic [DEPTH-1:0][DATA_W-1:0] bank_q;
   logic [DEPTH-1:0]             bank_en;

   assign busy = (state == COMMIT);

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : gen_bank
         assign bank_en[g] = busy && (hold.addr == ADDR_W'(g));
         register_bank_reg #(.DATA_W(DATA_W)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (bank_en[g]),
            .d     (hold.data),
            .q     (bank_q[g])
         );
      end
   endgenerate

   assign rd_data = bank_q[rd_addr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   // Readies are gated by reset so nothing is offered while it is held.
   always_comb begin
      nxt        = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (reset) begin
               req0_ready = req0_valid && (!req1_valid || !prio);
               req1_ready = req1_valid && (!req0_valid ||  prio);
            end
            if (req0_ready || req1_ready) nxt = COMMIT;
         end
         COMMIT:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   assign xfer = (req0_ready && req0_valid) || (req1_ready && req1_valid);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio    <= 1'b0;
         hold    <= '0;
         wr_done <= 1'b0;
         wr_src  <= 1'b0;
      end else begin
         wr_done <= busy;
         if (busy) wr_src <= hold.src;
         if (xfer) begin
            hold.src  <= req1_ready;
            hold.addr <= req1_ready ? req1_addr : req0_addr;
            hold.data <= req1_ready ? req1_data : req0_data;
            // pointer moves to whoever lost this round
            prio      <= ~req1_ready;
         end
      end
   end
endmodule
